// File: rtl/sniffer_pkg.sv
// sniffer_pkg: shared FSM states, event metadata and packet-id width for the match reporter.
package sniffer_pkg;
  localparam int PKT_ID_W = 16;
  typedef enum logic [2:0] {IDLE, IN_FRAME, DRAIN, REPORT, CLEAR} state_t;
  typedef struct packed {
    logic trunc;
    logic [PKT_ID_W-1:0] pkt_id;
  } evt_meta_t;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: event queue; a push while full succeeds only when a pop happens on the same cycle.
module event_fifo #(
  parameter int W = 21,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_pop, do_push;
  assign empty = wp == rp;
  assign full = (wp - rp) == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
endmodule

// File: rtl/match_reporter.sv
// match_reporter: collects comparator matches per frame and queues {trunc, flags, pkt_id} events.
// Define MATCH_REPORTER_IRQ_EN to enable the host interrupt; otherwise irq is tied low.
module match_reporter
  import sniffer_pkg::*;
#(
  parameter int NUM_CMP = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  word_valid,
  input  logic                  sof,
  input  logic                  eof,
  output logic                  frame_ready,
  input  logic [NUM_CMP-1:0]    match_vec,
  output logic                  cmp_clear,
  input  logic                  evt_rd,
  output logic                  evt_valid,
  output logic [16+NUM_CMP:0]   evt_data,
  output logic [7:0]            drop_cnt,
  output logic                  irq,
  input  logic                  irq_ack
);
  localparam int CW = $clog2(DRAIN_CYC + 2);
  localparam state_t AFTER_EOF = (DRAIN_CYC == 0) ? REPORT : DRAIN;
  state_t state;
  logic [NUM_CMP-1:0] flags;
  logic trunc;
  logic [PKT_ID_W-1:0] pkt_id;
  logic [CW-1:0] cnt;
  logic push, pushed, full, empty;
  evt_meta_t meta;
  assign frame_ready = state == IDLE || state == IN_FRAME;
  assign cmp_clear = state == CLEAR;
  assign push = state == REPORT && (|flags || trunc);
  assign pushed = push && (!full || evt_rd);
  assign evt_valid = !empty;
  assign meta = '{trunc: trunc, pkt_id: pkt_id};
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      flags <= '0;
      trunc <= 1'b0;
      pkt_id <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (word_valid && sof) begin
          flags <= match_vec;
          cnt <= CW'(DRAIN_CYC);
          state <= eof ? AFTER_EOF : IN_FRAME;
        end
        IN_FRAME: begin
          flags <= flags | match_vec;
          // a fresh sof without eof closes the current frame as truncated
          if (word_valid && (eof || sof)) begin
            trunc <= !eof;
            cnt <= CW'(DRAIN_CYC);
            state <= AFTER_EOF;
          end
        end
        DRAIN: begin
          flags <= flags | match_vec;
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) state <= REPORT;
        end
        REPORT: begin
          pkt_id <= pkt_id + 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          flags <= '0;
          trunc <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) drop_cnt <= '0;
    else if (push && !pushed && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
`ifdef MATCH_REPORTER_IRQ_EN
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) irq <= 1'b0;
    else irq <= pushed ? 1'b1 : irq_ack ? 1'b0 : irq;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif
  event_fifo #(.W(17 + NUM_CMP), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .n_rst(n_rst),
    .push(push),
    .pop(evt_rd),
    .din({meta.trunc, flags, meta.pkt_id}),
    .dout(evt_data),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_match_reporter.sv
// tb_match_reporter: scoreboard bench; expected events queued at REPORT, compared when the host reads.
module tb_match_reporter;
  localparam int DEPTH = 8;
  logic clk = 0, n_rst = 0, word_valid = 0, sof = 0, eof = 0, evt_rd = 0, irq_ack = 0;
  logic [3:0] match_vec = '0;
  logic frame_ready, cmp_clear, evt_valid, irq;
  logic [20:0] evt_data;
  logic [7:0] drop_cnt;
  int total = 0, bad = 0, occ = 0, drops = 0;
  logic [15:0] id_m = '0;
  logic irq_m = 0;
  logic [20:0] q[$];
  match_reporter #(.NUM_CMP(4), .FIFO_DEPTH(DEPTH), .DRAIN_CYC(2)) dut (
    .clk(clk), .n_rst(n_rst), .word_valid(word_valid), .sof(sof), .eof(eof),
    .frame_ready(frame_ready), .match_vec(match_vec), .cmp_clear(cmp_clear),
    .evt_rd(evt_rd), .evt_valid(evt_valid), .evt_data(evt_data),
    .drop_cnt(drop_cnt), .irq(irq), .irq_ack(irq_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input bit s, input bit e, input logic [3:0] mv);
    int t = 0;
    while (!frame_ready && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) check("ready_timeout", 0, 1);
    word_valid = 1; sof = s; eof = e; match_vec = mv;
    tick();
    word_valid = 0; sof = 0; eof = 0; match_vec = '0;
  endtask
  task automatic finish(input logic [3:0] fl, input bit tr, input bit rd, input bit ack);
    bit full_m, pushed;
    tick();
    tick();
    full_m = occ == DEPTH;
    pushed = 0;
    if (rd) begin
      check("rd_at_report", evt_data, q.pop_front());
      occ--;
      evt_rd = 1;
    end
    if (fl != 0 || tr) begin
      if (full_m && !rd) drops++;
      else begin
        q.push_back({tr, fl, id_m});
        occ++;
        pushed = 1;
      end
    end
    irq_ack = ack;
`ifdef MATCH_REPORTER_IRQ_EN
    irq_m = pushed ? 1'b1 : ack ? 1'b0 : irq_m;
`endif
    tick();
    evt_rd = 0;
    irq_ack = 0;
    check("cmp_clear_3_after_eof", cmp_clear, 1);
    check("ready_low_in_clear", frame_ready, 0);
    check("irq", irq, irq_m);
    check("drop_cnt", drop_cnt, drops);
    check("evt_valid", evt_valid, occ != 0);
    tick();
    check("ready_back", frame_ready, 1);
    check("clear_done", cmp_clear, 0);
    id_m++;
  endtask
  task automatic frame(input int n, input logic [3:0] mv, input bit rd, input bit ack);
    for (int i = 0; i < n; i++)
      send_word(i == 0, i == n - 1, (i == (n > 1 ? 1 : 0)) ? mv : 4'b0);
    finish(mv, 0, rd, ack);
  endtask
  task automatic read_all();
    while (q.size() > 0) begin
      check("valid_before_read", evt_valid, 1);
      check("evt_data", evt_data, q.pop_front());
      evt_rd = 1;
      tick();
      evt_rd = 0;
      occ--;
    end
    check("empty_after_reads", evt_valid, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", frame_ready, 1);
    check("rst_valid", evt_valid, 0);
    check("rst_clear", cmp_clear, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_irq", irq, 0);
    n_rst = 1;
    tick();
    frame(4, 4'b0001, 0, 0);
    read_all();
    frame(3, 4'b0000, 0, 0);
    check("no_match_no_event", evt_valid, 0);
    send_word(1, 0, 4'b0);
    send_word(0, 0, 4'b0100);
    send_word(1, 0, 4'b0);
    finish(4'b0100, 1, 0, 0);
    frame(2, 4'b0010, 0, 0);
    read_all();
    evt_rd = 1;
    tick();
    evt_rd = 0;
    check("rd_empty_ignored", evt_valid, 0);
    frame(1, 4'b1000, 0, 1);
    read_all();
    for (int k = 0; k < 9; k++) frame(2, 4'b0011, 0, 0);
    check("drop_after_9", drop_cnt, 1);
    frame(2, 4'b0011, 1, 0);
    read_all();
    frame(2, 4'b1000, 0, 0);
    send_word(1, 0, 4'b0);
    send_word(0, 1, 4'b0001);
    tick();
    n_rst = 0;
    #1;
    check("rst_drain_valid", evt_valid, 0);
    check("rst_drain_ready", frame_ready, 1);
    check("rst_drain_clear", cmp_clear, 0);
    check("rst_drain_drop", drop_cnt, 0);
    q.delete();
    occ = 0; drops = 0; id_m = '0; irq_m = 0;
    @(negedge clk);
    n_rst = 1;
    tick();
    frame(3, 4'b0101, 0, 0);
    read_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
